par2ser_frame_feeder: RTL and testbench
=======================================

// Module: par2ser_frame_feeder
// PURPOSE
//  Upstream feeder for the serial parity-classifier FSM. Accepts parallel words over a
//  valid/ready handshake and serialises each word into a frame of one bit per clk.
//  Drives frm_clr into the classifier's sync reset in the cycle before each frame.
//  Pulses frm_done in the cycle the classifier's one-hot class outputs cover the whole frame.
// PARAMETERS
//  WIDTH       8  bits per word/frame (>=2)
//  GAP_CYCLES  1  idle cycles before each frame (>=1); frm_clr is asserted on the last one
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  in_data   in   WIDTH  parallel word
//  in_valid  in   1      in_data valid
//  in_ready  out  1      holding register empty; word accepted when in_valid&&in_ready at edge
//  ser_x     out  1      serial bit (classifier x); 0 when ser_valid=0
//  ser_valid out  1      ser_x carries a frame bit this cycle
//  frm_clr   out  1      one-cycle pulse; classifier sync reset, precedes the frame's first bit
//  frm_done  out  1      one-cycle pulse, cycle after the frame's last bit
//  busy      out  1      state!=IDLE or holding register full
// BEHAVIOUR
//  - Storage: 1-entry holding reg (hold, hold_full) plus WIDTH-bit shift reg sh.
//    bit_cnt is $clog2(WIDTH) wide; gap_cnt is $clog2(GAP_CYCLES+1) wide.
//  - in_ready = !hold_full, a registered term only (no combinational path from in_valid).
//  - Reset: state=IDLE, hold_full=0, sh=0, counters=0.
//    Outputs: ser_x=0, ser_valid=0, frm_clr=0, frm_done=0, busy=0, in_ready=1.
//  - FSM (registered state, Moore outputs):
//    IDLE:  if hold_full -> GAP, sh<=hold, hold_full<=0, gap_cnt<=GAP_CYCLES-1.
//    GAP:   frm_clr=(gap_cnt==0). If gap_cnt==0 -> SHIFT, bit_cnt<=0; else gap_cnt-1.
//    SHIFT: ser_valid=1, ser_x=sh[WIDTH-1]; sh<<=1; bit_cnt+1.
//           On bit_cnt==WIDTH-1: if hold_full -> GAP (load as in IDLE), else -> IDLE.
//  - frm_done: register set on the SHIFT last-bit edge, so high exactly one cycle after the last bit.
//    That cycle is IDLE or the first GAP cycle; with GAP_CYCLES=1 it coincides with frm_clr.
//  - Accept and load on the same edge: the load empties hold and the accept refills it.
//    Legal only when in_ready was 1, so this cannot occur with hold full.
//  - Latency: a word accepted at edge k with IDLE and hold empty enters GAP at edge k+1.
//    First bit is presented after edge k+1+GAP_CYCLES.
//  - Throughput: with hold kept full, one frame every WIDTH+GAP_CYCLES cycles; ser_valid never stalls mid-frame.
//  - Reset mid-frame: frame truncated, held word dropped; no frm_done for the truncated frame.
//  - in_data is ignored when in_valid=0. in_valid dropped without acceptance is legal (no retention).
// CONFIGURATION
//  SER_LSB_FIRST_EN defined:   ser_x=sh[0], sh>>=1 (LSB first).
//  SER_LSB_FIRST_EN undefined: MSB first as above.
//  Frame timing and handshake are identical in both builds.
// TESTING
//  1 rst 2 cycles, then idle -> in_ready=1, busy=0, ser_valid=0, ser_x=0.
//  2 WIDTH=8, GAP=1, send 0xA5 at edge k -> frm_clr in cycle after k+1.
//    ser_x=1,0,1,0,0,1,0,1 in the following 8 cycles; frm_done next; classifier A=1 (4 ones, 4 zeros).
//  3 Send 0xFF then 0x01 back-to-back -> second frame starts 9 cycles after the first.
//    frm_done and frm_clr in the same cycle; in_ready=0 while the second word is held.
//  4 Hold in_valid=1 with 3 words -> each accepted only when in_ready=1; none lost or duplicated.
//    Output order preserved.
//  5 rst after 3 bits of 0xC3 -> next cycle: ser_valid=0, busy=0, in_ready=1; no frm_done.
//  6 GAP=3: frm_clr only in the 3rd gap cycle.
//    With SER_LSB_FIRST_EN, 0x01 -> first ser_x=1, then seven 0s.

Source files
------------

// File: rtl/par2ser_frame_feeder.sv
// par2ser_frame_feeder: feeds the serial parity classifier.
// Parallel words arrive over a valid/ready handshake and wait in a one-entry holding
// register. Each word is sent as a frame of WIDTH serial bits, one bit per clock. Before
// each frame the block waits GAP_CYCLES idle cycles and pulses frm_clr on the last of them.
// frm_done pulses in the cycle after the last bit of a frame.
// Build option: define SER_LSB_FIRST_EN to send the LSB first. When it is not defined,
// the MSB goes first. Frame timing and the handshake are the same in both builds.
module par2ser_frame_feeder #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_x,
    output logic             ser_valid,
    output logic             frm_clr,
    output logic             frm_done,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GAP   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             frm_done_q, frm_done_d;
    logic             accept;

    // Bit presented on the serial line for the current shift-register contents
    function automatic logic serial_bit(input logic [WIDTH-1:0] sh);
`ifdef SER_LSB_FIRST_EN
        return sh[0];
`else
        return sh[WIDTH-1];
`endif
    endfunction

    // Shift-register contents after one bit has been sent
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] sh);
`ifdef SER_LSB_FIRST_EN
        return {1'b0, sh[WIDTH-1:1]};
`else
        return {sh[WIDTH-2:0], 1'b0};
`endif
    endfunction

    // in_ready depends only on flop state, so there is no path from in_valid to in_ready
    assign in_ready  = !hold_full_q;
    assign accept    = in_valid && !hold_full_q;

    assign ser_valid = (state_q == S_SHIFT);
    assign ser_x     = ser_valid && serial_bit(sh_q);
    assign frm_clr   = (state_q == S_GAP) && (gap_cnt_q == '0);
    assign frm_done  = frm_done_q;
    assign busy      = (state_q != S_IDLE) || hold_full_q;

    // Next-state logic: frame sequencing, loading from the holding register, and accept
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frm_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    state_d     = S_GAP;
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    gap_cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            S_SHIFT: begin
                sh_d      = shift_next(sh_q);
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    frm_done_d = 1'b1;
                    // A waiting word goes straight into its gap, so frames do not stall
                    if (hold_full_q) begin
                        state_d     = S_GAP;
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                        gap_cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept is only possible with hold empty, so a load on the same edge never loses a word
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    // Control and shift state, with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frm_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frm_done_q  <= frm_done_d;
        end
    end

    // Holding-register data; hold_full_q already qualifies it, so it has no reset
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_par2ser_frame_feeder.sv
// Bench for par2ser_frame_feeder. The driver predicts each frame as a timeline from
// the accept edge and pushes the expected events into queues. A monitor process checks
// the DUT outputs against those queues on every falling edge.
// A second instance with GAP_CYCLES=3 covers the longer gap. SER_LSB_FIRST_EN selects
// the expected bit order.
module tb_par2ser_frame_feeder;

    localparam int W  = 8;
    localparam int G  = 1;
    localparam int G3 = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, ser_x, ser_valid, frm_clr, frm_done, busy;

    logic [W-1:0] in_data3 = '0;
    logic         in_valid3 = 1'b0;
    logic         in_ready3, ser_x3, ser_valid3, frm_clr3, frm_done3, busy3;

    always #5 clk = ~clk;

    par2ser_frame_feeder #(.WIDTH(W), .GAP_CYCLES(G)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_x(ser_x), .ser_valid(ser_valid), .frm_clr(frm_clr), .frm_done(frm_done), .busy(busy)
    );

    par2ser_frame_feeder #(.WIDTH(W), .GAP_CYCLES(G3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .ser_x(ser_x3), .ser_valid(ser_valid3), .frm_clr(frm_clr3), .frm_done(frm_done3), .busy(busy3)
    );

    typedef struct {
        int   c;
        logic b;
    } bit_ev_t;

    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;
    // reference model: hold is full during cycles [hold_k, hold_l); last frame ends at edge e_last
    int      hold_k = 0;
    int      hold_l = 0;
    int      e_last = 0;
    int      last_fb = 0;
    bit      accepted = 1'b0;
    bit_ev_t bit_q[$];
    int      clr_q[$];
    int      done_q[$];

    function automatic bit model_ready(input int c);
        return !(c >= hold_k && c < hold_l);
    endfunction

    function automatic logic exp_bit(input logic [W-1:0] d, input int i);
`ifdef SER_LSB_FIRST_EN
        return d[i];
`else
        return d[W-1-i];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Word accepted at edge cyc: it loads at the later of the next edge and the previous
    // frame's end. The gap follows, then the bits, then done.
    task automatic accept_word(input logic [W-1:0] d);
        int l, fb;
        bit_ev_t ev;
        l  = (cyc + 1 > e_last) ? cyc + 1 : e_last;
        fb = l + G;
        for (int i = 0; i < W; i++) begin
            ev.c = fb + i;
            ev.b = exp_bit(d, i);
            bit_q.push_back(ev);
        end
        clr_q.push_back(fb - 1);
        done_q.push_back(fb + W);
        hold_k  = cyc;
        hold_l  = l;
        e_last  = fb + W;
        last_fb = fb;
    endtask

    task automatic tick();
        bit pre_ready;
        pre_ready = model_ready(cyc);
        @(posedge clk);
        cyc++;
        accepted = 1'b0;
        if (rst) begin
            bit_q.delete();
            clr_q.delete();
            done_q.delete();
            hold_k = 0;
            hold_l = 0;
            e_last = 0;
        end else if (in_valid && pre_ready) begin
            accept_word(in_data);
            accepted = 1'b1;
        end
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL send_word_timeout cycle=%0d actual=not_accepted required=accepted", cyc);
        end
    endtask

    // Monitor: compare every cycle's outputs with the events the model scheduled for it
    always @(negedge clk) begin
        bit      exp_sv, exp_clr, exp_done;
        bit_ev_t ev;
        if (cyc >= 1) begin
            check("in_ready", in_ready, model_ready(cyc));
            check("busy", busy, cyc < e_last);
            exp_sv = (bit_q.size() > 0) && (bit_q[0].c == cyc);
            check("ser_valid", ser_valid, exp_sv);
            if (exp_sv) begin
                ev = bit_q.pop_front();
                check("ser_x", ser_x, ev.b);
            end else begin
                check("ser_x_idle", ser_x, 1'b0);
            end
            exp_clr = (clr_q.size() > 0) && (clr_q[0] == cyc);
            check("frm_clr", frm_clr, exp_clr);
            if (exp_clr) void'(clr_q.pop_front());
            exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
            check("frm_done", frm_done, exp_done);
            if (exp_done) void'(done_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int           fb;
        logic [W-1:0] d;
        logic [W-1:0] one;
        // reset, then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // single word
        send_word(8'hA5);
        in_valid = 1'b0;
        repeat (12) tick();

        // back-to-back words
        send_word(8'hFF);
        send_word(8'h01);
        in_valid = 1'b0;
        repeat (22) tick();

        // valid held across three words
        for (int i = 0; i < 3; i++) send_word(W'($urandom));
        in_valid = 1'b0;
        repeat (35) tick();

        // reset after three bits, with a second word held
        send_word(8'hC3);
        fb = last_fb;
        send_word(8'h3C);
        in_valid = 1'b0;
        for (int n = 0; n < 20 && cyc < fb + 2; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();

        // random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if (!(in_valid && !accepted && $urandom_range(3) != 0)) begin
                in_valid = ($urandom_range(2) != 0);
                in_data  = W'($urandom);
            end
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (40) tick();
        check("drain_empty", bit_q.size() + clr_q.size() + done_q.size(), 0);

        // three-cycle gap instance, word 0x01
        one = 8'h01;
        in_data3  = one;
        in_valid3 = 1'b1;
        check("in_ready3", in_ready3, 1'b1);
        tick();
        in_valid3 = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            check("frm_clr3", frm_clr3, c == 3);
            check("ser_valid3", ser_valid3, c >= 4 && c <= 11);
            d[0] = (c >= 4 && c <= 11) ? exp_bit(one, c - 4) : 1'b0;
            check("ser_x3", ser_x3, d[0]);
            check("frm_done3", frm_done3, c == 12);
            check("busy3", busy3, c <= 11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
